// File: rtl/seq_mult_param.sv
// seq_mult_param: multi-cycle shift-add multiplier with optional two's-complement mode.
// Operand magnitudes are multiplied unsigned, and the product sign is applied at completion.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter bit SIGNED_EN = 1
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               enable_signal,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum;
  logic neg, sgn, last;
  always_comb begin
    sgn = SIGNED_EN && sign_mode;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    acc_n = {sum, acc[WIDTH-1:1]};
    last = cnt == CW'(WIDTH-1);
    state_n = state == IDLE ? (enable_signal ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  assign busy = state == RUN;
  // Lower half of acc holds the multiplier and is consumed one bit per iteration
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      out_data <= '0;
      done <= 1'b0;
      acc <= '0;
      mcand <= '0;
      neg <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      if (state == IDLE) begin
        if (enable_signal) begin
          mcand <= (sgn && input_a[WIDTH-1]) ? -input_a : input_a;
          acc <= {{WIDTH{1'b0}}, ((sgn && input_b[WIDTH-1]) ? -input_b : input_b)};
          neg <= sgn && (input_a[WIDTH-1] ^ input_b[WIDTH-1]);
          cnt <= '0;
        end
      end else begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          out_data <= neg ? -acc_n : acc_n;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed bench for three multiplier configurations with a cycle-level model.
module tb_seq_mult_param;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int wd[3] = '{32, 8, 16};
  bit sen[3] = '{1, 0, 1};
  logic [63:0] a_i[3], b_i[3], o_i[3];
  logic rn[3], en[3], sm[3], bz[3], dn[3];
  logic [63:0] o0;
  logic [15:0] o1;
  logic [31:0] o2;
  assign o_i[0] = o0;
  assign o_i[1] = {48'b0, o1};
  assign o_i[2] = {32'b0, o2};
  seq_mult_param #(.WIDTH(32), .SIGNED_EN(1)) u32 (.clock_in(clk), .reset(rn[0]), .enable_signal(en[0]),
    .sign_mode(sm[0]), .input_a(a_i[0][31:0]), .input_b(b_i[0][31:0]), .out_data(o0), .busy(bz[0]), .done(dn[0]));
  seq_mult_param #(.WIDTH(8), .SIGNED_EN(0)) u8 (.clock_in(clk), .reset(rn[1]), .enable_signal(en[1]),
    .sign_mode(sm[1]), .input_a(a_i[1][7:0]), .input_b(b_i[1][7:0]), .out_data(o1), .busy(bz[1]), .done(dn[1]));
  seq_mult_param #(.WIDTH(16), .SIGNED_EN(1)) u16 (.clock_in(clk), .reset(rn[2]), .enable_signal(en[2]),
    .sign_mode(sm[2]), .input_a(a_i[2][15:0]), .input_b(b_i[2][15:0]), .out_data(o2), .busy(bz[2]), .done(dn[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference product straight from integer arithmetic, truncated to 2*w bits
  function automatic logic [63:0] prod(input logic [63:0] a, input logic [63:0] b, input logic s, input int w);
    logic [63:0] mask, am, bm;
    longint sa, sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    am = a & ((64'd1 << w) - 64'd1);
    bm = b & ((64'd1 << w) - 64'd1);
    sa = longint'(am << (64 - w)) >>> (64 - w);
    sb = longint'(bm << (64 - w)) >>> (64 - w);
    return s ? (64'(sa * sb) & mask) : ((am * bm) & mask);
  endfunction

  logic mv[3] = '{0, 0, 0}, mb[3], md[3];
  logic [63:0] mo[3], mp[3];
  int ml[3];
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (!rn[k]) begin
        mv[k] = 1; mb[k] = 0; md[k] = 0; mo[k] = 0;
      end else if (mb[k]) begin
        ml[k]--;
        if (ml[k] == 0) begin mb[k] = 0; md[k] = 1; mo[k] = mp[k]; end
      end else begin
        md[k] = 0;
        if (en[k]) begin
          mb[k] = 1; ml[k] = wd[k];
          mp[k] = prod(a_i[k], b_i[k], sm[k] && sen[k], wd[k]);
        end
      end
    end

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (mv[k]) begin
        chk($sformatf("busy%0d", k), 64'(bz[k]), 64'(mb[k]));
        chk($sformatf("done%0d", k), 64'(dn[k]), 64'(md[k]));
        chk($sformatf("out%0d", k), o_i[k], mo[k]);
      end

  task automatic start(input int k, input logic [63:0] a, input logic [63:0] b, input logic s);
    a_i[k] = a; b_i[k] = b; sm[k] = s; en[k] = 1;
    @(negedge clk);
    en[k] = 0;
  endtask

  task automatic wait_done(input int k, output int n, output int nb);
    n = 0; nb = 0;
    while (!dn[k] && n < 200) begin
      if (bz[k]) nb++;
      @(negedge clk);
      n++;
    end
    chk("timeout", 64'(dn[k]), 64'd1);
  endtask

  task automatic run(input int k, input logic [63:0] a, input logic [63:0] b, input logic s,
                     input logic [63:0] exp, input string nm);
    int n, nb;
    start(k, a, b, s);
    wait_done(k, n, nb);
    chk({nm, "_lat"}, 64'(n), 64'(wd[k]));
    chk(nm, o_i[k], exp);
  endtask

  initial begin
    int n, nb, nd;
    for (int k = 0; k < 3; k++) begin
      rn[k] = 0; en[k] = 0; sm[k] = 0; a_i[k] = 0; b_i[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rn[k] = 1;
    chk("rst_out", o_i[0], 64'd0);
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_done", 64'(dn[0]), 64'd0);
    repeat (50) @(negedge clk);
    chk("idle_out", o_i[0], 64'd0);
    chk("idle_busy", 64'(bz[0]), 64'd0);

    start(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
    wait_done(0, n, nb);
    chk("umax_busy_cycles", 64'(nb), 64'd32);
    chk("umax_lat", 64'(n), 64'd32);
    chk("umax", o_i[0], 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_fall", 64'(dn[0]), 64'd0);
    run(0, 64'hFFFF_FFFD, 64'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1, "m3x5");
    run(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'h0000_0000_0000_0001, "m1xm1");
    run(0, 64'h8000_0000, 64'h8000_0000, 1, 64'h4000_0000_0000_0000, "minxmin");
    run(0, 64'h8000_0000, 64'd1, 1, 64'hFFFF_FFFF_8000_0000, "minx1");

    start(0, 64'd7, 64'd9, 0);
    repeat (9) @(negedge clk);
    a_i[0] = 64'hFFFF; b_i[0] = 64'hFFFF; en[0] = 1;
    @(negedge clk);
    en[0] = 0;
    wait_done(0, n, nb);
    chk("ign_lat", 64'(n + 10), 64'd32);
    chk("ign_res", o_i[0], 64'd63);
    nd = 0;
    repeat (40) begin @(negedge clk); if (dn[0]) nd++; end
    chk("ign_no_done", 64'(nd), 64'd0);
    chk("ign_hold", o_i[0], 64'd63);

    run(1, 64'd255, 64'd255, 1, 64'hFE01, "u8max");
    a_i[1] = 3; b_i[1] = 4; sm[1] = 0; en[1] = 1;
    @(negedge clk);
    en[1] = 0;
    n = 1;
    while (!dn[1] && n < 50) begin @(negedge clk); n++; end
    chk("b2b_lat", 64'(n), 64'd9);
    chk("b2b_res", o_i[1], 64'h000C);

    start(2, 64'd1000, 64'd1000, 0);
    repeat (4) @(negedge clk);
    rn[2] = 0;
    @(negedge clk);
    rn[2] = 1;
    chk("abort_busy", 64'(bz[2]), 64'd0);
    chk("abort_out", o_i[2], 64'd0);
    nd = 0;
    repeat (30) begin @(negedge clk); if (dn[2]) nd++; end
    chk("abort_no_done", 64'(nd), 64'd0);
    run(2, 64'd1000, 64'd1000, 0, 64'h000F_4240, "fresh");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
